// File: rtl/hall_pkg.sv
// Shared hall-sensor definitions: sector lookup, invalid codes, direction
// encoding and the per-edge event classification used by the decoder.
package hall_pkg;

    // Codes that can never come from a healthy 120-degree hall set.
    localparam logic [2:0] HALL_INV_LO = 3'b000;
    localparam logic [2:0] HALL_INV_HI = 3'b111;

    // Direction encoding, identical to the gate driver's d input.
    localparam logic FWD = 1'b1;
    localparam logic REV = 1'b0;

    // What a filtered code change means to the decoder.
    typedef enum logic [2:0] {
        EV_NONE,   // nothing to do
        EV_LOAD,   // first valid code since reset: sector learned
        EV_FWD,    // one sector forward
        EV_REV,    // one sector backward
        EV_SKIP,   // jumped two or more sectors
        EV_BAD     // 000 or 111
    } hall_evt_e;

    function automatic logic hall_code_valid(input logic [2:0] code);
        return (code != HALL_INV_LO) && (code != HALL_INV_HI);
    endfunction

    // Commutation order for d = 1: 1,3,2,6,4,5 -> sectors 0..5.
    function automatic logic [2:0] hall_sector(input logic [2:0] code);
        logic [2:0] s;
        case (code)
            3'd1:    s = 3'd0;
            3'd3:    s = 3'd1;
            3'd2:    s = 3'd2;
            3'd6:    s = 3'd3;
            3'd4:    s = 3'd4;
            3'd5:    s = 3'd5;
            default: s = 3'd0;
        endcase
        return s;
    endfunction

    // (to - from) mod 6 for sectors in 0..5. When to < from the 3-bit
    // difference wraps mod 8, so adding 6 (mod 8) lands on the mod-6 result.
    function automatic logic [2:0] hall_delta(input logic [2:0] from,
                                              input logic [2:0] to);
        return (to >= from) ? (to - from) : (to - from + 3'd6);
    endfunction

endpackage

// File: rtl/hall_filter.sv
// Synchroniser plus stability filter for the raw hall bus. A new code is
// accepted only after FILT_CYCLES consecutive identical synchronised samples.
module hall_filter
    import hall_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] h_raw_i,
    output logic [2:0] h_filt_o,
    output logic       h_chg_o
);

    localparam int unsigned CNT_W = $clog2(FILT_CYCLES + 1);

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  h_sync;
    logic [2:0]                  cand_q, cand_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [CNT_W-1:0]            run_len;
    logic [2:0]                  filt_q, filt_d;
    logic                        chg_q, chg_d;

    assign h_sync   = sync_q[SYNC_STAGES-1];
    assign h_filt_o = filt_q;
    assign h_chg_o  = chg_q;

    // Metastability chain: the raw bus is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], h_raw_i};
        end
    end

    // Run-length count of the candidate; a change of code restarts it and a
    // return to the accepted code abandons it.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        chg_d   = 1'b0;
        run_len = '0;
        if (h_sync == filt_q) begin
            cand_d = h_sync;
            cnt_d  = '0;
        end else begin
            run_len = (h_sync != cand_q) ? CNT_W'(1) : cnt_q + CNT_W'(1);
            cand_d  = h_sync;
            if (run_len >= CNT_W'(FILT_CYCLES)) begin
                filt_d = h_sync;
                chg_d  = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = run_len;
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= '0;
            cnt_q  <= '0;
            filt_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            chg_q  <= chg_d;
        end
    end

endmodule

// File: rtl/hall_decoder.sv
// Hall decoder: turns filtered hall codes into step pulses, direction, a
// signed position count, step period and stall/error flags for one motor.
module hall_decoder
    import hall_pkg::*;
#(
    parameter int unsigned          SYNC_STAGES = 2,
    parameter int unsigned          FILT_CYCLES = 8,
    parameter int unsigned          PERIOD_W    = 24,
    parameter int unsigned          POS_W       = 16,
    parameter logic [PERIOD_W-1:0]  TIMEOUT     = {PERIOD_W{1'b1}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          h_raw,
    input  logic                clr,
    output logic [2:0]          h_filt,
    output logic                step,
    output logic                dir,
    output logic [POS_W-1:0]    position,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stalled,
    output logic                hall_err
);

    logic [2:0]          filt;
    logic                h_chg;
    logic [2:0]          new_sec;
    logic [2:0]          delta;
    hall_evt_e           evt;
    logic                is_step;
    logic                step_dir;

    logic [2:0]          sec_q, sec_d;
    logic                known_q, known_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    logic                step_q, step_d;
    logic                err_q, err_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic                pv_q, pv_d;
    logic                stall_q, stall_d;
    logic                prev_q, prev_d;   // a step has happened since reset

    hall_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .h_raw_i  (h_raw),
        .h_filt_o (filt),
        .h_chg_o  (h_chg)
    );

    assign h_filt       = filt;
    assign step         = step_q;
    assign dir          = dir_q;
    assign position     = pos_q;
    assign period       = per_q;
    assign period_valid = pv_q;
    assign stalled      = stall_q;
    assign hall_err     = err_q;

    // Classify the code change presented by the filter this cycle.
    always_comb begin
        evt     = EV_NONE;
        new_sec = hall_sector(filt);
        delta   = hall_delta(sec_q, new_sec);
        if (h_chg) begin
            if (!hall_code_valid(filt)) begin
                evt = EV_BAD;
            end else if (!known_q) begin
                evt = EV_LOAD;
            end else begin
                case (delta)
                    3'd0:    evt = EV_NONE;
                    3'd1:    evt = EV_FWD;
                    3'd5:    evt = EV_REV;
                    default: evt = EV_SKIP;
                endcase
            end
        end
        is_step  = (evt == EV_FWD) || (evt == EV_REV);
        step_dir = (evt == EV_FWD) ? FWD : REV;
    end

    // Next-state for sector, position, period and stall tracking.
    always_comb begin
        sec_d   = sec_q;
        known_d = known_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = 1'b0;
        per_d   = per_q;
        pv_d    = pv_q;
        stall_d = stall_q;
        prev_d  = prev_q;

        // Cycles since the last step, saturating.
        if (is_step) begin
            cnt_d = PERIOD_W'(1);
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end

        case (evt)
            EV_BAD: begin
                err_d = 1'b1;
            end
            EV_LOAD: begin
                sec_d   = new_sec;
                known_d = 1'b1;
            end
            EV_SKIP: begin
                err_d = 1'b1;
                sec_d = new_sec;
                pv_d  = 1'b0;
            end
            EV_FWD, EV_REV: begin
                sec_d   = new_sec;
                step_d  = 1'b1;
                dir_d   = step_dir;
                per_d   = cnt_q;
                // Only a second consecutive same-direction step out of a
                // running (non-stalled) state yields a trustworthy period.
                pv_d    = prev_q && (step_dir == dir_q) && !stall_q;
                prev_d  = 1'b1;
                stall_d = 1'b0;
            end
            default: ;
        endcase

        // clr wins over a same-cycle step.
        if (clr) begin
            pos_d = '0;
        end else if (evt == EV_FWD) begin
            pos_d = pos_q + POS_W'(1);
        end else if (evt == EV_REV) begin
            pos_d = pos_q - POS_W'(1);
        end

        if (!is_step && (cnt_q == TIMEOUT)) begin
            stall_d = 1'b1;
            pv_d    = 1'b0;
            per_d   = '1;
        end
    end

    // Decoder state registers; stalled comes out of reset asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q   <= '0;
            known_q <= 1'b0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            per_q   <= '0;
            pv_q    <= 1'b0;
            stall_q <= 1'b1;
            prev_q  <= 1'b0;
        end else begin
            sec_q   <= sec_d;
            known_q <= known_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            pv_q    <= pv_d;
            stall_q <= stall_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: tb/tb_hall_decoder.sv
// Bench for hall_decoder: directed scenarios with literal expectations plus
// randomized hall traffic compared every cycle against a behavioural model.
module tb_hall_decoder;

    localparam int S   = 2;
    localparam int F   = 8;
    localparam int PW  = 24;
    localparam int PSW = 16;
    localparam int TO  = 1000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2:0]     h_raw = 3'd0;
    logic           clr = 1'b0;
    logic [2:0]     h_filt;
    logic           step;
    logic           dir;
    logic [PSW-1:0] position;
    logic [PW-1:0]  period;
    logic           period_valid;
    logic           stalled;
    logic           hall_err;

    hall_decoder #(
        .SYNC_STAGES (S),
        .FILT_CYCLES (F),
        .PERIOD_W    (PW),
        .POS_W       (PSW),
        .TIMEOUT     (24'd1000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .h_raw        (h_raw),
        .clr          (clr),
        .h_filt       (h_filt),
        .step         (step),
        .dir          (dir),
        .position     (position),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled),
        .hall_err     (hall_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int nstep    = 0;
    int nerr     = 0;

    // sector of each code (-1 = invalid) and code of each sector
    int sec_of [8] = '{-1, 0, 2, 1, 4, 5, 3, -1};
    int code_of[6] = '{1, 3, 2, 6, 4, 5};

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    int             hist[S+F];   // hist[k] = raw sampled k edges ago
    logic [2:0]     m_filt;
    bit             m_chg;
    int             m_sec;
    bit             m_known;
    logic [PSW-1:0] m_pos;
    bit             m_dir, m_step, m_err, m_pv, m_stall, m_hasprev;
    logic [PW-1:0]  m_per;
    longint         cyc  = 0;
    longint         last = 1;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < S + F; i++) hist[i] = 0;
            m_filt = 3'd0; m_chg = 1'b0; m_known = 1'b0; m_sec = 0;
            m_pos = '0; m_dir = 1'b0; m_step = 1'b0; m_err = 1'b0;
            m_pv = 1'b0; m_stall = 1'b1; m_hasprev = 1'b0; m_per = '0;
            last = cyc + 1;
        end else begin
            longint elapsed;
            bit     stepped, fwd;
            int     delta, ns;
            bit     same;
            cyc++;
            elapsed = cyc - last;
            if (elapsed > 64'(2**PW - 1)) elapsed = 64'(2**PW - 1);
            m_step = 1'b0; m_err = 1'b0; stepped = 1'b0; fwd = 1'b0;
            if (m_chg) begin
                ns = sec_of[m_filt];
                if (ns < 0) m_err = 1'b1;
                else if (!m_known) begin m_sec = ns; m_known = 1'b1; end
                else begin
                    delta = (ns - m_sec + 6) % 6;
                    m_sec = ns;
                    if (delta == 1 || delta == 5) begin stepped = 1'b1; fwd = (delta == 1); end
                    else if (delta != 0) begin m_err = 1'b1; m_pv = 1'b0; end
                end
            end
            if (stepped) begin
                m_step = 1'b1;
                m_pv = m_hasprev && (fwd == m_dir) && !m_stall;
                m_per = PW'(elapsed);
                m_dir = fwd; m_hasprev = 1'b1; m_stall = 1'b0; last = cyc;
                if (clr) m_pos = '0;
                else if (fwd) m_pos = m_pos + 1'b1;
                else m_pos = m_pos - 1'b1;
            end else begin
                if (clr) m_pos = '0;
                if (elapsed == TO) begin m_stall = 1'b1; m_pv = 1'b0; m_per = '1; end
            end
            // filter: accept a code seen on the last F synchronised samples
            for (int i = S + F - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(h_raw);
            same = 1'b1;
            for (int i = S; i < S + F; i++) if (hist[i] != hist[S]) same = 1'b0;
            m_chg = 1'b0;
            if (same && (3'(hist[S]) != m_filt)) begin m_filt = 3'(hist[S]); m_chg = 1'b1; end
        end
    end

    // per-cycle comparison, away from the active edge
    always begin
        @(negedge clk);
        if (chk_en) begin
            chk("h_filt", h_filt, m_filt);
            chk("step", step, m_step);
            chk("dir", dir, m_dir);
            chk("position", position, m_pos);
            chk("period", period, m_per);
            chk("period_valid", period_valid, m_pv);
            chk("stalled", stalled, m_stall);
            chk("hall_err", hall_err, m_err);
        end
        if (rst_n) begin
            if (step) nstep++;
            if (hall_err) nerr++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base_s, base_e, cur, code, r, hold;
        logic [2:0] prev;

        tick(3);
        chk_en = 1'b1;
        chk("rst_stalled", stalled, 1);
        chk("rst_h_filt", h_filt, 0);
        chk("rst_position", position, 0);
        chk("rst_period_valid", period_valid, 0);
        rst_n = 1'b1;
        tick(5);

        // forward rotation, 100 cycles per code
        base_s = nstep;
        for (int i = 0; i < 7; i++) begin
            h_raw = 3'(code_of[i % 6]);
            tick(100);
        end
        chk("fwd_steps", nstep - base_s, 6);
        chk("fwd_position", position, 6);
        chk("fwd_dir", dir, 1);
        chk("fwd_period", period, 100);
        chk("fwd_period_valid", period_valid, 1);
        chk("fwd_stalled", stalled, 0);

        // reversal
        h_raw = 3'd5; tick(100);
        chk("rev1_position", position, 5);
        chk("rev1_dir", dir, 0);
        chk("rev1_period_valid", period_valid, 0);
        h_raw = 3'd4; tick(100);
        chk("rev2_position", position, 4);
        chk("rev2_period_valid", period_valid, 1);
        chk("rev2_period", period, 100);

        // back to code 1 forward, then a short glitch
        h_raw = 3'd5; tick(100);
        h_raw = 3'd1; tick(100);
        base_s = nstep; base_e = nerr;
        h_raw = 3'd3; tick(5);
        h_raw = 3'd1; tick(50);
        chk("glitch_h_filt", h_filt, 1);
        chk("glitch_steps", nstep - base_s, 0);
        chk("glitch_errs", nerr - base_e, 0);

        // invalid code, recovery, skipped sector
        base_e = nerr;
        h_raw = 3'd7; tick(20);
        chk("inv_errs", nerr - base_e, 1);
        chk("inv_position", position, 6);
        h_raw = 3'd3; tick(100);
        chk("recover_position", position, 7);
        base_s = nstep; base_e = nerr;
        h_raw = 3'd6; tick(100);
        chk("skip_errs", nerr - base_e, 1);
        chk("skip_steps", nstep - base_s, 0);
        chk("skip_period_valid", period_valid, 0);

        // reverse step 6->2 then hold into stall
        h_raw = 3'd2; tick(S + F + 1);
        chk("stall_pre_step", step, 1);
        tick(TO - 1);
        chk("stall_not_yet", stalled, 0);
        tick(1);
        chk("stall_set", stalled, 1);
        chk("stall_period", period, 24'hFFFFFF);
        chk("stall_period_valid", period_valid, 0);

        // clr coincident with a forward step 2->6
        h_raw = 3'd6; tick(S + F);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("clr_step", step, 1);
        chk("clr_position", position, 0);
        chk("clr_stalled", stalled, 0);
        tick(20);

        // asynchronous reset mid-rotation
        rst_n = 1'b0; #1;
        chk("async_stalled", stalled, 1);
        chk("async_h_filt", h_filt, 0);
        chk("async_position", position, 0);
        chk("async_step", step, 0);
        chk("async_period_valid", period_valid, 0);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        chk("post_rst_h_filt", h_filt, 6);
        chk("post_rst_position", position, 0);

        // randomized traffic
        cur = 3;
        for (int it = 0; it < 250; it++) begin
            r = int'($urandom_range(0, 11));
            prev = h_raw;
            code = int'(prev);
            if (r < 6) begin
                cur = (cur + 1) % 6; code = code_of[cur];
            end else if (r < 9) begin
                cur = (cur + 5) % 6; code = code_of[cur];
            end else if (r == 9) begin
                code = int'($urandom_range(0, 7));
                if (sec_of[code] >= 0) cur = sec_of[code];
            end else begin
                h_raw = 3'($urandom_range(0, 7));
                tick(int'($urandom_range(1, 7)));
            end
            h_raw = 3'(code);
            clr = ($urandom_range(0, 15) == 0);
            hold = (it == 200) ? 1100 : int'($urandom_range(3, 40));
            tick(1);
            clr = 1'b0;
            tick(hold - 1);
            if (it == 120) begin
                rst_n = 1'b0; tick(2); rst_n = 1'b1;
            end
        end
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hall_decoder.md
Name: hall_decoder

Overview:
- Reads the 3-bit hall sensor bus that drives commutation in the BLDC gate driver.
- Synchronises and deglitches the raw hall bus.
- Decodes commutation steps into rotation direction, a signed position count and the step period.
- Output feeds the speed/position controller that generates the gate driver's pwm, d and brake inputs. One instance per motor.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on the raw hall bus (min 2).
- FILT_CYCLES, 8, cycles a new synchronised code must stay stable before it is accepted (min 1).
- PERIOD_W, 24, width of the period counter and period output.
- POS_W, 16, width of the signed position counter.
- TIMEOUT, 24'hFFFFFF, cycles without a valid step before stalled asserts (≤ 2^PERIOD_W−1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- h_raw  in  3  raw hall inputs {g,f,e}, asynchronous to clk
- clr  in  1  synchronous clear of position
- h_filt  out  3  filtered hall code
- step  out  1  one-cycle pulse per valid commutation step
- dir  out  1  1 = forward, 0 = reverse; direction of the last valid step
- position  out  POS_W  signed step count
- period  out  PERIOD_W  clk cycles between the last two valid steps
- period_valid  out  1  period is meaningful
- stalled  out  1  no valid step within TIMEOUT cycles
- hall_err  out  1  one-cycle pulse on an invalid code or a skipped sector

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. All outputs reset to 0 except stalled = 1. Internal sector = unknown.
- Sector map, shared with the gate driver's d = 1 commutation order: 1→0, 3→1, 2→2, 6→3, 4→4, 5→5. Codes 0 and 7 are invalid.
- Filter:
  - After the SYNC_STAGES synchroniser, a candidate code differing from h_filt loads a counter.
  - The counter increments while the code is unchanged.
  - When FILT_CYCLES consecutive equal samples are seen, h_filt takes the candidate.
  - Any change in the synchronised code restarts the count.
  - Latency: h_filt updates SYNC_STAGES+FILT_CYCLES edges after a clean raw change.
- Edge processing, on the edge after h_filt changes:
  - New code invalid: hall_err pulses; sector, position, dir and period are unchanged.
  - Sector unknown and new code valid: sector loaded; no step.
  - delta = (new − sector) mod 6:
    - delta 1: forward step; step = 1, dir = 1, position += 1.
    - delta 5: reverse step; step = 1, dir = 0, position −= 1.
    - delta 2, 3 or 4: hall_err pulses, no step, sector ← new, period_valid ← 0.
  - Sector is always updated on a valid code.
- Period:
  - A free-running counter increments each cycle, saturating at all ones, and resets to 1 on every step.
  - On a step, period ← counter value.
  - period_valid ← 1 only if this step and the previous step have the same direction and stalled was 0. Otherwise period_valid ← 0.
- Stall:
  - When the counter reaches TIMEOUT: stalled ← 1, period_valid ← 0, period ← all ones.
  - The next step clears stalled; period_valid stays 0 until one more same-direction step.
- Position: two's-complement wrap. clr has priority over a same-cycle step; position ← 0 but step, dir and period still update.
- Reset mid-operation: everything returns to reset values. The first valid code after reset only loads sector.

Decomposition:
- Package hall_pkg holds:
  - the sector lookup function and invalid-code constants 3'b000 and 3'b111;
  - FWD = 1 and REV = 0 direction constants, shared with the gate driver's d input.
- One sub-module, hall_filter: synchroniser plus stability filter, producing h_filt and a one-cycle h_chg pulse.

Test Plan:
- Reset: assert rst_n low mid-rotation → h_filt = 0, position = 0, step = 0, period_valid = 0, stalled = 1 immediately (asynchronous).
- Forward rotation: h_raw 1,3,2,6,4,5,1, each held 100 cycles → six step pulses, dir = 1, position = 6, period = 100, period_valid = 1 from the second step, stalled = 0.
- Reversal, continuing from the forward test: h_raw 1,5,4 → position = 4, dir = 0. period_valid = 0 after the first reverse step, 1 after the second with period = 100.
- Glitch: h_filt = 1, h_raw = 3 for 5 cycles then back to 1 (FILT_CYCLES = 8) → no h_filt change, no step, no hall_err.
- Errors:
  - 1→7 held 20 cycles → one hall_err pulse, position unchanged; then 7→3 → forward step, position +1.
  - 3→6 → hall_err pulse, no step, period_valid = 0.
- Stall and clr (TIMEOUT = 1000): hold h_raw constant → stalled = 1 exactly 1000 cycles after the last step, period = all ones. Drive clr in the same cycle as a step → position = 0, step = 1, stalled = 0.
